// File: rtl/fog_closed_loop_v2.sv
// Closed-loop fiber-optic gyro core: square-wave modulator, gated
// demodulator, error generator and feedback step/phase-ramp integrator.
module fog_closed_loop_v2 #(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AVG_MAX = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  input  logic        [31:0]        i_freq_cnt,
  input  logic signed [DATA_W-1:0]  i_amp_H,
  input  logic signed [DATA_W-1:0]  i_amp_L,
  input  logic                      i_polarity,
  input  logic        [15:0]        i_wait_cnt,
  input  logic signed [DATA_W-1:0]  i_err_offset,
  input  logic        [2:0]         i_avg_sel,
  input  logic        [4:0]         i_gain_sel,
  input  logic        [1:0]         i_mode,
  input  logic signed [DATA_W-1:0]  i_const_step,
  output logic signed [DATA_W-1:0]  o_mod_out,
  output logic                      o_status,
  output logic                      o_trig,
  output logic signed [DATA_W-1:0]  o_err,
  output logic                      o_err_vld,
  output logic signed [DATA_W-1:0]  o_step,
  output logic                      o_step_vld,
  output logic signed [DATA_W-1:0]  o_ramp
);

  localparam int unsigned ACC_W  = ADC_BIT + AVG_MAX + 1;
  localparam int unsigned DIF_W  = ACC_W + 1;
  localparam int unsigned EXT_W  = DATA_W + DIF_W + 2;
  localparam int unsigned SCNT_W = AVG_MAX + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_DONE} state_t;

  logic        [31:0]        r_cnt;
  logic        [31:0]        r_n;
  logic                      r_status;
  logic                      r_trig;
  logic signed [DATA_W-1:0]  r_mod;
  state_t                    r_state;
  logic        [15:0]        r_wait;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [SCNT_W-1:0]  r_samp;
  logic signed [ACC_W-1:0]   r_sum_h;
  logic                      r_sum_h_vld;
  logic signed [DIF_W-1:0]   r_diff;
  logic                      r_diff_vld;
  logic signed [DATA_W-1:0]  r_err;
  logic                      r_err_vld;
  logic signed [DATA_W-1:0]  r_step;
  logic                      r_step_vld;
  logic signed [DATA_W-1:0]  r_ramp;
  logic                      r_prev_open;

  logic        [31:0]        w_n_new;
  logic                      w_wrap;
  logic        [2:0]         w_avg;
  logic        [SCNT_W-1:0]  w_samp_last;
  logic signed [ACC_W-1:0]   w_adc_ext;
  logic signed [DIF_W-1:0]   w_sh;
  logic signed [EXT_W-1:0]   w_e_ext;
  logic signed [EXT_W-1:0]   w_off_ext;
  logic signed [EXT_W-1:0]   w_pol;
  logic signed [EXT_W-1:0]   w_res;
  logic                      w_res_fits;
  logic signed [DATA_W-1:0]  w_err_sat;
  logic signed [DATA_W-1:0]  w_gain_sh;
  logic signed [DATA_W:0]    w_step_sum;
  logic signed [DATA_W-1:0]  w_step_sat;
  logic                      w_open;

  assign w_n_new     = (i_freq_cnt < 32'd2) ? 32'd2 : i_freq_cnt;
  assign w_wrap      = (r_cnt == r_n - 32'd1);
  assign w_avg       = (i_avg_sel > 3'(AVG_MAX)) ? 3'(AVG_MAX) : i_avg_sel;
  assign w_samp_last = (SCNT_W'(1) << w_avg) - SCNT_W'(1);
  assign w_adc_ext   = {{(ACC_W-ADC_BIT){i_adc_data[ADC_BIT-1]}}, i_adc_data};

  // error path: scale, polarity, offset, saturate to DATA_W
  assign w_sh       = r_diff >>> w_avg;
  assign w_e_ext    = {{(EXT_W-DIF_W){w_sh[DIF_W-1]}}, w_sh};
  assign w_off_ext  = {{(EXT_W-DATA_W){i_err_offset[DATA_W-1]}}, i_err_offset};
  assign w_pol      = i_polarity ? -w_e_ext : w_e_ext;
  assign w_res      = w_pol - w_off_ext;
  assign w_res_fits = (&w_res[EXT_W-1:DATA_W-1]) | ~(|w_res[EXT_W-1:DATA_W-1]);
  assign w_err_sat  = w_res_fits ? w_res[DATA_W-1:0] : (w_res[EXT_W-1] ? SAT_MIN : SAT_MAX);

  // closed-loop step: accumulate scaled error with saturation
  assign w_gain_sh  = r_err >>> i_gain_sel;
  assign w_step_sum = {r_step[DATA_W-1], r_step} + {w_gain_sh[DATA_W-1], w_gain_sh};
  assign w_step_sat = (w_step_sum[DATA_W] != w_step_sum[DATA_W-1])
                      ? (w_step_sum[DATA_W] ? SAT_MIN : SAT_MAX)
                      : w_step_sum[DATA_W-1:0];
  assign w_open     = (i_mode == 2'd0) || (i_mode == 2'd3);

  // half-period modulator; period length latched only at reload
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_n      <= w_n_new;
      r_status <= 1'b0;
      r_trig   <= 1'b0;
      r_mod    <= '0;
    end else begin
      r_trig <= w_wrap;
      if (w_wrap) begin
        r_cnt    <= '0;
        r_n      <= w_n_new;
        r_status <= ~r_status;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      r_mod <= (w_wrap ? ~r_status : r_status) ? i_amp_H : i_amp_L;
    end
  end

  // demodulator FSM: settle, accumulate 2^A samples, pair high/low halves
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_acc       <= '0;
      r_samp      <= '0;
      r_sum_h     <= '0;
      r_sum_h_vld <= 1'b0;
      r_diff      <= '0;
      r_diff_vld  <= 1'b0;
    end else begin
      r_diff_vld <= 1'b0;
      if (r_trig) begin
        if (r_state == S_DONE && !r_status) begin
          r_sum_h     <= r_acc;
          r_sum_h_vld <= 1'b1;
        end else begin
          r_sum_h_vld <= 1'b0;
          if (r_state == S_DONE && r_sum_h_vld) begin
            r_diff     <= {r_sum_h[ACC_W-1], r_sum_h} - {r_acc[ACC_W-1], r_acc};
            r_diff_vld <= 1'b1;
          end
        end
        r_wait  <= i_wait_cnt;
        r_acc   <= '0;
        r_samp  <= '0;
        r_state <= (i_wait_cnt == 16'd0) ? S_ACC : S_WAIT;
      end else begin
        case (r_state)
          S_WAIT: begin
            r_wait <= r_wait - 16'd1;
            if (r_wait <= 16'd1) r_state <= S_ACC;
          end
          S_ACC: begin
            r_acc  <= r_acc + w_adc_ext;
            r_samp <= r_samp + SCNT_W'(1);
            if (r_samp == w_samp_last) r_state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // registered error output, held between pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err     <= '0;
      r_err_vld <= 1'b0;
    end else begin
      r_err_vld <= r_diff_vld;
      if (r_diff_vld) r_err <= w_err_sat;
    end
  end

  // feedback step and phase ramp; entering open mode clears both
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step      <= '0;
      r_step_vld  <= 1'b0;
      r_ramp      <= '0;
      r_prev_open <= 1'b1;
    end else begin
      r_prev_open <= w_open;
      r_step_vld  <= r_err_vld;
      if (r_err_vld) begin
        case (i_mode)
          2'd1:    r_step <= w_step_sat;
          2'd2:    r_step <= i_const_step;
          default: r_step <= '0;
        endcase
      end
      if (r_step_vld) r_ramp <= r_ramp + r_step;
      if (w_open && !r_prev_open) begin
        r_step <= '0;
        r_ramp <= '0;
      end
    end
  end

  assign o_mod_out  = r_mod;
  assign o_status   = r_status;
  assign o_trig     = r_trig;
  assign o_err      = r_err;
  assign o_err_vld  = r_err_vld;
  assign o_step     = r_step;
  assign o_step_vld = r_step_vld;
  assign o_ramp     = r_ramp;

endmodule

// File: tb/tb_fog_closed_loop_v2.sv
// Bench for fog_closed_loop_v2: vector table for the error path, a
// scoreboard for err/step/ramp, and hand sequences for timing corners.
module tb_fog_closed_loop_v2;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic signed [13:0] i_adc_data;
  logic        [31:0] i_freq_cnt = 32'd100;
  logic signed [31:0] i_amp_H = 32'sd1000;
  logic signed [31:0] i_amp_L = -32'sd1000;
  logic               i_polarity = 1'b0;
  logic        [15:0] i_wait_cnt = 16'd10;
  logic signed [31:0] i_err_offset = '0;
  logic        [2:0]  i_avg_sel = 3'd3;
  logic        [4:0]  i_gain_sel = '0;
  logic        [1:0]  i_mode = 2'd0;
  logic signed [31:0] i_const_step = '0;
  logic signed [31:0] o_mod_out, o_err, o_step, o_ramp;
  logic               o_status, o_trig, o_err_vld, o_step_vld;

  logic signed [13:0] adc_h = '0;
  logic signed [13:0] adc_l = '0;
  assign i_adc_data = o_status ? adc_h : adc_l;

  always #5 clk = ~clk;

  fog_closed_loop_v2 dut (
    .i_clk(clk), .i_rst(i_rst), .i_adc_data(i_adc_data), .i_freq_cnt(i_freq_cnt),
    .i_amp_H(i_amp_H), .i_amp_L(i_amp_L), .i_polarity(i_polarity),
    .i_wait_cnt(i_wait_cnt), .i_err_offset(i_err_offset), .i_avg_sel(i_avg_sel),
    .i_gain_sel(i_gain_sel), .i_mode(i_mode), .i_const_step(i_const_step),
    .o_mod_out(o_mod_out), .o_status(o_status), .o_trig(o_trig), .o_err(o_err),
    .o_err_vld(o_err_vld), .o_step(o_step), .o_step_vld(o_step_vld), .o_ramp(o_ramp)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [31:0] q_err[$];
  logic signed [31:0] q_step[$];
  logic signed [31:0] q_ramp[$];
  bit ramp_chk = 1'b0;

  function automatic void check(string name, logic signed [31:0] act, logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, req, req);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endfunction

  // scoreboard: compare every err/step pulse and the ramp one cycle after a step
  always @(negedge clk) begin
    if (i_rst) begin
      ramp_chk = 1'b0;
    end else begin
      if (ramp_chk) begin
        ramp_chk = 1'b0;
        if (q_ramp.size() == 0) fail_now("ramp_unexpected");
        else check("ramp", o_ramp, q_ramp.pop_front());
      end
      if (o_err_vld) begin
        if (q_err.size() == 0) fail_now("err_unexpected");
        else check("err", o_err, q_err.pop_front());
      end
      if (o_step_vld) begin
        if (q_step.size() == 0) fail_now("step_unexpected");
        else check("step", o_step, q_step.pop_front());
        ramp_chk = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // which: 0 err_vld, 1 step_vld, 2 trig; returns negedges waited
  task automatic wait_evt(input int which, input int budget, output int cyc);
    bit hit = 1'b0;
    int c = 0;
    while (!hit && c < budget) begin
      @(negedge clk);
      c++;
      case (which)
        0:       hit = o_err_vld;
        1:       hit = o_step_vld;
        default: hit = o_trig;
      endcase
    end
    if (!hit) fail_now($sformatf("timeout_evt%0d", which));
    cyc = c;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_mod_out"}, o_mod_out, 0);
    check({tag, "_status"}, 32'(o_status), 0);
    check({tag, "_trig"}, 32'(o_trig), 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_err_vld"}, 32'(o_err_vld), 0);
    check({tag, "_step"}, o_step, 0);
    check({tag, "_step_vld"}, 32'(o_step_vld), 0);
    check({tag, "_ramp"}, o_ramp, 0);
  endtask

  typedef struct {
    logic               pol;
    logic signed [31:0] off;
    logic signed [13:0] h;
    logic signed [13:0] l;
    logic [2:0]         avg;
    logic signed [31:0] err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c;
    int n_e, n_s, n_t;
    bit exp_status;

    vecs[0] = '{1'b0, 32'sd0,          14'sd300,   14'sd100,   3'd3, 32'sd200};
    vecs[1] = '{1'b1, 32'sd0,          14'sd300,   14'sd100,   3'd3, -32'sd200};
    vecs[2] = '{1'b0, 32'sd5,          14'sd300,   14'sd100,   3'd3, 32'sd195};
    vecs[3] = '{1'b0, 32'sd0,          14'sd300,   14'sd100,   3'd7, 32'sd200};
    vecs[4] = '{1'b0, 32'sd0,          -14'sd50,   14'sd70,    3'd0, -32'sd120};
    vecs[5] = '{1'b0, 32'h8000_0064,   14'sd300,   14'sd100,   3'd3, 32'h7FFF_FFFF};
    vecs[6] = '{1'b1, 32'h7FFF_FFFF,   14'sd300,   14'sd100,   3'd3, 32'h8000_0000};
    vecs[7] = '{1'b0, 32'sd0,          14'sd8191,  -14'sd8192, 3'd3, 32'sd16383};

    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    i_rst = 1'b0;

    // modulator cadence with zero ADC input
    q_err.push_back(0); q_step.push_back(0); q_ramp.push_back(0);
    wait_evt(2, 150, c);
    check("first_trig_lat", c, 100);
    check("trig_status", 32'(o_status), 1);
    check("trig_mod_out", o_mod_out, 32'sd1000);
    exp_status = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("trig_one_cycle", 32'(o_trig), 0);
      wait_evt(2, 150, c);
      exp_status = ~exp_status;
      check("trig_period", c, 99);
      check("status_toggle", 32'(o_status), 32'(exp_status));
      check("mod_out_level", o_mod_out, exp_status ? 32'sd1000 : -32'sd1000);
    end

    // error-path vector table, open mode
    for (int i = 0; i < 8; i++) begin
      i_polarity   = vecs[i].pol;
      i_err_offset = vecs[i].off;
      adc_h        = vecs[i].h;
      adc_l        = vecs[i].l;
      i_avg_sel    = vecs[i].avg;
      do_reset();
      q_err.push_back(vecs[i].err); q_step.push_back(0); q_ramp.push_back(0);
      wait_evt(0, 400, c);
      if (i == 0) check("err_latency", c, 302);
      wait_evt(1, 4, c);
      repeat (3) @(negedge clk);
    end

    // closed loop integration: step +50 each period
    i_polarity = 1'b0; i_err_offset = 0; adc_h = 14'sd300; adc_l = 14'sd100;
    i_avg_sel = 3'd3; i_mode = 2'd1; i_gain_sel = 5'd2;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      q_err.push_back(200);
      q_step.push_back(32'(50 * k));
      q_ramp.push_back(32'(25 * k * (k + 1)));
    end
    for (int k = 0; k < 3; k++) begin
      wait_evt(0, 400, c);
      wait_evt(1, 4, c);
    end
    repeat (2) @(negedge clk);
    check("pre_open_step", o_step, 150);
    i_mode = 2'd0;
    @(negedge clk);
    check("open_clr_step", o_step, 0);
    check("open_clr_ramp", o_ramp, 0);

    // const then closed: step saturates, ramp wraps
    i_mode = 2'd2; i_const_step = 32'h7FFF_FFF0; i_gain_sel = 5'd0; adc_h = 14'sd500;
    do_reset();
    q_err.push_back(400); q_err.push_back(400); q_err.push_back(400);
    q_step.push_back(32'h7FFF_FFF0); q_step.push_back(32'h7FFF_FFFF); q_step.push_back(32'h7FFF_FFFF);
    q_ramp.push_back(32'h7FFF_FFF0); q_ramp.push_back(32'hFFFF_FFEF); q_ramp.push_back(32'h7FFF_FFEE);
    wait_evt(0, 400, c);
    wait_evt(1, 4, c);
    repeat (2) @(negedge clk);
    i_mode = 2'd1;
    for (int k = 0; k < 2; k++) begin
      wait_evt(0, 250, c);
      wait_evt(1, 4, c);
    end
    repeat (2) @(negedge clk);

    // half-period too short for the requested average: no error ever
    i_freq_cnt = 32'd20; i_avg_sel = 3'd4; adc_h = 14'sd300;
    do_reset();
    n_e = 0; n_s = 0; n_t = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n_e += int'(o_err_vld);
      n_s += int'(o_step_vld);
      n_t += int'(o_trig);
    end
    check("short_err_cnt", n_e, 0);
    check("short_step_cnt", n_s, 0);
    check("short_trig_cnt", n_t, 20);
    check("short_step", o_step, 0);

    // reset in the middle of accumulation
    i_freq_cnt = 32'd100; i_avg_sel = 3'd3; i_mode = 2'd2; i_const_step = 32'sd77;
    do_reset();
    q_err.push_back(200); q_step.push_back(77); q_ramp.push_back(77);
    wait_evt(0, 400, c);
    wait_evt(1, 4, c);
    wait_evt(2, 150, c);
    repeat (14) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check_all_zero("midacc");
    i_rst = 1'b0;
    q_err.push_back(200); q_step.push_back(77); q_ramp.push_back(77);
    wait_evt(0, 400, c);
    check("post_rst_err_lat", c, 302);
    wait_evt(1, 4, c);
    repeat (3) @(negedge clk);

    check("q_err_left", q_err.size(), 0);
    check("q_step_left", q_step.size(), 0);
    check("q_ramp_left", q_ramp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
